// File: rtl/mole_autoplayer_if.sv
// Mole/button bundle between the whack-a-mole core side and the autoplayer.
// The master side (core or bench) drives enable and mole levels; the slave side is the player.
interface mole_autoplayer_if #(
   parameter int unsigned CNT_W = 4
) ();
   logic             enable;
   logic             mo1;
   logic             mo2;
   logic             mo3;
   logic             mo4;
   logic             in1;
   logic             in2;
   logic             in3;
   logic             in4;
   logic [CNT_W-1:0] hits;
   logic [CNT_W-1:0] misses;
   logic             busy;

   modport master (
      output enable, mo1, mo2, mo3, mo4,
      input  in1, in2, in3, in4, hits, misses, busy
   );

   modport slave (
      input  enable, mo1, mo2, mo3, mo4,
      output in1, in2, in3, in4, hits, misses, busy
   );
endinterface

// File: rtl/mole_autoplayer.sv
// Whack-a-mole autoplayer: targets the lowest raised mole and pulses its button after a reaction delay.
// Optional macro MOLE_AUTOPLAYER_BOUNCE_EN prefixes each press with a 1,0,1,0 contact-bounce burst.
module mole_autoplayer #(
   parameter int unsigned REACT_CYCLES = 3,
   parameter int unsigned PRESS_CYCLES = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic            clk,
   input  logic            rst,
   mole_autoplayer_if.slave bus
);

   localparam int unsigned TMR_W = 9;
`ifdef MOLE_AUTOPLAYER_BOUNCE_EN
   localparam int unsigned BURST_CYCLES = 4;
`else
   localparam int unsigned BURST_CYCLES = 0;
`endif
   localparam logic [TMR_W-1:0] REACT_LOAD = TMR_W'(REACT_CYCLES - 1);
   localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(PRESS_CYCLES + BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_PRESS   = 2'd2,
      S_RELEASE = 2'd3
   } state_e;

   state_e           state_q,  state_d;
   logic [TMR_W-1:0] timer_q,  timer_d;
   logic [1:0]       target_q, target_d;
   logic [3:0]       press_q,  press_d;
   logic [CNT_W-1:0] hits_q,   hits_d;
   logic [CNT_W-1:0] misses_q, misses_d;
   logic             busy_q,   busy_d;

   logic [3:0] mo_c;
   logic [1:0] lowest_c;
   logic       mo_tgt_c;

   assign mo_c     = {bus.mo4, bus.mo3, bus.mo2, bus.mo1};
   assign mo_tgt_c = mo_c[target_q];

   // mo1 has the highest priority
   always_comb begin
      lowest_c = 2'd3;
      if (mo_c[0])      lowest_c = 2'd0;
      else if (mo_c[1]) lowest_c = 2'd1;
      else if (mo_c[2]) lowest_c = 2'd2;
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      target_d = target_q;
      press_d  = press_q;
      hits_d   = hits_q;
      misses_d = misses_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.enable && (mo_c != 4'd0)) begin
               target_d = lowest_c;
               timer_d  = REACT_LOAD;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!mo_tgt_c) begin
               misses_d = (misses_q == CNT_MAX) ? misses_q : misses_q + CNT_W'(1);
               state_d  = S_IDLE;
            end else if (timer_q == '0) begin
               press_d = 4'b0001 << target_q;
               hits_d  = (hits_q == CNT_MAX) ? hits_q : hits_q + CNT_W'(1);
               timer_d = PRESS_LOAD;
               state_d = S_PRESS;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         S_PRESS: begin
            if (timer_q == '0) begin
               press_d = '0;
               state_d = S_RELEASE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
`ifdef MOLE_AUTOPLAYER_BOUNCE_EN
               // Burst cycles 1 and 3 of the press window are the low bounces
               if ((timer_q == PRESS_LOAD) || (timer_q == PRESS_LOAD - TMR_W'(2)))
                  press_d = '0;
               else
                  press_d = 4'b0001 << target_q;
`endif
            end
         end
         S_RELEASE: begin
            if (!mo_tgt_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         target_q <= '0;
         press_q  <= '0;
         hits_q   <= '0;
         misses_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         target_q <= target_d;
         press_q  <= press_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.in1    = press_q[0];
   assign bus.in2    = press_q[1];
   assign bus.in3    = press_q[2];
   assign bus.in4    = press_q[3];
   assign bus.hits   = hits_q;
   assign bus.misses = misses_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mole_autoplayer.sv
// Self-checking bench for mole_autoplayer: elapsed-cycle behavioural model, directed cases, random moles.
module tb_mole_autoplayer;

   localparam int unsigned REACT = 3;
   localparam int unsigned PRESS = 4;
   localparam int unsigned CNT_W = 4;
`ifdef MOLE_AUTOPLAYER_BOUNCE_EN
   localparam int unsigned BURST = 4;
`else
   localparam int unsigned BURST = 0;
`endif
   localparam int PW   = int'(PRESS + BURST);
   localparam int R    = int'(REACT);
   localparam int CMAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mole_autoplayer_if #(.CNT_W(CNT_W)) bus ();

   mole_autoplayer #(
      .REACT_CYCLES(REACT),
      .PRESS_CYCLES(PRESS),
      .CNT_W       (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: mode 0 idle, 1 tracking a target (k = edges since start), 2 waiting for mole to drop
   int m_mode = 0;
   int m_k = 0;
   int m_tgt = 0;
   int m_hits = 0;
   int m_misses = 0;

   function automatic int exp_in();
      int e;
      if (m_mode != 1 || m_k < R || m_k >= R + PW) return 0;
      e = m_k - R;
      if (BURST > 0 && (e == 1 || e == 3)) return 0;
      return 1 << m_tgt;
   endfunction

   always @(posedge clk) begin
      logic [3:0] mo;
      mo = {bus.mo4, bus.mo3, bus.mo2, bus.mo1};
      if (rst) begin
         m_mode = 0; m_k = 0; m_tgt = 0; m_hits = 0; m_misses = 0;
      end else begin
         case (m_mode)
            0: if (bus.enable && mo != 4'd0) begin
                  m_tgt = 3;
                  for (int i = 3; i >= 0; i--) if (mo[i]) m_tgt = i;
                  m_k = 0;
                  m_mode = 1;
               end
            1: begin
                  m_k++;
                  if (m_k <= R && !mo[m_tgt]) begin
                     if (m_misses < CMAX) m_misses++;
                     m_mode = 0;
                  end else begin
                     if (m_k == R && m_hits < CMAX) m_hits++;
                     if (m_k == R + PW) m_mode = 2;
                  end
               end
            default: if (!mo[m_tgt]) m_mode = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("in_lines", int'({bus.in4, bus.in3, bus.in2, bus.in1}), exp_in());
      chk("hits", int'(bus.hits), m_hits);
      chk("misses", int'(bus.misses), m_misses);
      chk("busy", int'(bus.busy), int'(m_mode != 0));
   end

   task automatic step(input bit r, input bit en, input logic [3:0] mo);
      rst = r;
      bus.enable = en;
      {bus.mo4, bus.mo3, bus.mo2, bus.mo1} = mo;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int cnt2, cnt4;
      int hold[4];
      logic [3:0] mo_r;
      bus.enable = 1'b0;
      {bus.mo4, bus.mo3, bus.mo2, bus.mo1} = 4'd0;

      // Reset state
      step(1, 0, 4'd0);
      chk("rst_in", int'({bus.in4, bus.in3, bus.in2, bus.in1}), 0);
      chk("rst_hits", int'(bus.hits), 0);
      chk("rst_busy", int'(bus.busy), 0);

`ifndef MOLE_AUTOPLAYER_BOUNCE_EN
      // mo1 held: press on edges N+3..N+6
      for (int j = 0; j <= 8; j++) begin
         step(0, 1, 4'b0001);
         chk("d1_in1", int'(bus.in1), int'(j >= 3 && j <= 6));
      end
      chk("d1_hits", int'(bus.hits), 1);
      chk("d1_misses", int'(bus.misses), 0);
      chk("d1_busy_rel", int'(bus.busy), 1);
      step(0, 1, 4'd0);
      chk("d1_busy_idle", int'(bus.busy), 0);
`else
      // mo4 held: burst 1,0,1,0 then solid for PRESS cycles
      begin
         int exp_b[12] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0};
         for (int j = 0; j < 12; j++) begin
            step(0, 1, 4'b1000);
            chk("bounce_in4", int'(bus.in4), exp_b[j]);
         end
      end
      chk("bounce_hits", int'(bus.hits), 1);
      step(0, 1, 4'd0);
`endif

      // Short mo3 blip is a miss
      step(1, 0, 4'd0);
      step(0, 1, 4'b0100);
      step(0, 1, 4'b0100);
      step(0, 1, 4'd0);
      chk("d2_misses", int'(bus.misses), 1);
      chk("d2_hits", int'(bus.hits), 0);
      chk("d2_busy", int'(bus.busy), 0);

      // mo2 and mo4 together: mo2 first, then mo4
      step(1, 0, 4'd0);
      cnt2 = 0; cnt4 = 0;
      for (int j = 0; j < 12; j++) begin
         step(0, 1, 4'b1010);
         cnt2 += int'(bus.in2);
         cnt4 += int'(bus.in4);
      end
      chk("d3_in2_count", cnt2, int'(PRESS + BURST / 2));
      chk("d3_in4_quiet", cnt4, 0);
      cnt2 = 0;
      for (int j = 0; j < 14; j++) begin
         step(0, 1, 4'b1000);
         cnt2 += int'(bus.in2);
         cnt4 += int'(bus.in4);
      end
      chk("d3_in4_count", cnt4, int'(PRESS + BURST / 2));
      chk("d3_in2_quiet", cnt2, 0);
      chk("d3_hits", int'(bus.hits), 2);

      // Reset during the press
      step(1, 0, 4'd0);
      for (int j = 0; j <= 3; j++) step(0, 1, 4'b0001);
      chk("d4_in1_pressed", int'(bus.in1), 1);
      step(1, 1, 4'b0001);
      chk("d4_in1", int'(bus.in1), 0);
      chk("d4_hits", int'(bus.hits), 0);
      chk("d4_busy", int'(bus.busy), 0);

      // Twenty hits saturate the counter
      step(1, 0, 4'd0);
      for (int n = 0; n < 20; n++) begin
         for (int j = 0; j <= R + PW; j++) step(0, 1, 4'b0001);
         step(0, 1, 4'd0);
      end
      chk("d5_hits_sat", int'(bus.hits), 15);
      chk("d5_misses", int'(bus.misses), 0);

      // Random mole traffic
      step(1, 0, 4'd0);
      mo_r = 4'd0;
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               mo_r[i] = 1'($urandom_range(0, 1));
               hold[i] = int'($urandom_range(1, 12));
            end else begin
               hold[i]--;
            end
         end
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, mo_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mole_autoplayer.md
Name: mole_autoplayer

Overview:
- Automated player for the whack-a-mole game: watches the four mole outputs and pulses the matching hit-button line after a programmable reaction delay.
- Sits on the opposite side of the game core's interface. Its mo1..mo4 inputs come from the core's mole outputs; its in1..in4 outputs drive the core's button inputs.
- Used for self-play regression and demo mode.
- Keeps its own hit and miss tallies so its counts can be cross-checked against the core's count.

Parameters:
- REACT_CYCLES, 3: clock cycles from mole detection to press assertion; legal range 1..255.
- PRESS_CYCLES, 4: clock cycles the press line is held high once asserted; legal range 1..255.
- CNT_W, 4: width of the hits and misses counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when high, new moles may be targeted.
- mo1  input  1  mole 1 up (level).
- mo2  input  1  mole 2 up (level).
- mo3  input  1  mole 3 up (level).
- mo4  input  1  mole 4 up (level).
- in1  output  1  press line for mole 1 (registered).
- in2  output  1  press line for mole 2 (registered).
- in3  output  1  press line for mole 3 (registered).
- in4  output  1  press line for mole 4 (registered).
- hits  output  CNT_W  presses started while the target mole was up; saturating.
- misses  output  CNT_W  targets lost before pressing; saturating.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - rst is synchronous and active-high; it overrides everything, including mid-operation.
  - On any rising edge with rst=1: state=IDLE, in1..in4=0, hits=0, misses=0, busy=0, target=0, timer=0.
- States: IDLE, WAIT, PRESS, RELEASE.
- IDLE:
  - Transition: on an edge where enable=1 and any mo is high, latch target = lowest-index high mole (mo1 has highest priority), load timer=REACT_CYCLES-1 and go to WAIT. Call this edge N.
  - Hold: otherwise stay in IDLE.
- WAIT:
  - Mole lost: if mo[target]=0 on an edge, misses increments (saturating) and the state returns to IDLE.
  - Timer expiry: if timer==0 and mo[target]=1, assert in[target], increment hits (saturating), load timer=PRESS_CYCLES-1 and go to PRESS.
  - Otherwise: decrement timer.
  - Result: in[target] goes high exactly at edge N+REACT_CYCLES.
- PRESS:
  - in[target] is held high regardless of mo; timer decrements each edge.
  - When timer==0, in[target] deasserts and the state moves to RELEASE.
  - Press width is exactly PRESS_CYCLES cycles.
- RELEASE:
  - Stay while mo[target]=1.
  - Go to IDLE on the first edge where mo[target]=0.
  - Prevents re-hitting the same mole instance.
- Only one press line is ever high at a time. Other moles rising while busy are ignored until IDLE re-evaluates them.
- enable:
  - Sampled only in IDLE.
  - Deasserting it mid-sequence does not abort; the current sequence completes.
- Counters saturate at 2^CNT_W-1 and never wrap.
- mo inputs are level signals used directly; the game core is on the same clock.

Optional Feature:
- Macro: MOLE_AUTOPLAYER_BOUNCE_EN.
- Defined:
  - The press starts with a contact-bounce burst on in[target] of 1,0,1,0 over 4 cycles starting at edge N+REACT_CYCLES, then solid high for PRESS_CYCLES cycles.
  - PRESS state lasts PRESS_CYCLES+4 cycles.
  - hits increments once, at the first rising of the burst.
  - Used to exercise the core's debouncing.
- Undefined: clean press exactly as described in Behaviour.

Test Plan:
- Defaults, enable=1, mo1 rises and stays high, first sampled at edge N -> in1 high at edges N+3..N+6 inclusive of assertion, low from N+7; hits=1, misses=0; busy returns low on the edge after mo1 falls.
- mo3 pulses high for 2 cycles only -> no press on any line; misses=1 on the edge mo3 is seen low in WAIT; back in IDLE.
- mo2 and mo4 rise on the same edge -> target=mo2; only in2 pulses; after mo2 falls, mo4 (still high) is targeted next and in4 pulses; hits=2.
- rst asserted during PRESS with in1=1 -> next edge: in1=0, hits=0, misses=0, state IDLE.
- 20 consecutive hits with CNT_W=4 -> hits saturates at 15.
- With MOLE_AUTOPLAYER_BOUNCE_EN defined and mo4 held high -> in4 sequence 1,0,1,0 then high for 4 cycles; hits=1.
